aes_cbc_chain: RTL and testbench
================================

Name: aes_cbc_chain

Overview:
Sequencing stage between the Wishbone AES register wrapper and the AES-128 encryption core. Takes the 128-bit plaintext block and the one-cycle start strobe from the wrapper, optionally XORs the block with a chaining value (CBC mode), launches the core and waits for its done. Returns the ciphertext plus a one-cycle done pulse to the wrapper and updates the chaining value.

Parameters:
BW, 128, block width in bits; only 128 is supported.
TIMEOUT_CYCLES, 64, WAIT-state watchdog limit; used only with AES_CBC_TIMEOUT_EN.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset; synchronous, active-high
enc_cs_i  in  1  start strobe from wrapper; one cycle
plaintext_i  in  BW  plaintext block; sampled when enc_cs_i is accepted
mode_cbc_i  in  1  1=CBC, 0=ECB; sampled with enc_cs_i
iv_i  in  BW  initialisation vector
iv_load_i  in  1  load iv_i into the chaining register
core_start_o  out  1  one-cycle launch pulse to the core
core_data_o  out  BW  block presented to the core
core_done_i  in  1  core result valid, one cycle
core_data_i  in  BW  core ciphertext
ciphertext_o  out  BW  last completed ciphertext
enc_done_o  out  1  one-cycle completion pulse to the wrapper
busy_o  out  1  block in flight
overrun_o  out  1  sticky: enc_cs_i arrived while busy
err_o  out  1  sticky: watchdog expired; tied 0 without the macro

Behaviour:
- Reset: synchronous. All outputs and the chain register go to 0 and the state goes to IDLE. Reset mid-operation abandons the block. No enc_done_o is produced, and a late core_done_i seen in IDLE is ignored.
- FSM states are IDLE, START and WAIT. All outputs are registered or Moore-decoded: core_start_o = (state==START), busy_o = (state!=IDLE).
- IDLE, iv_load_i=1: chain <= iv_i.
- IDLE, enc_cs_i=1:
  - core_data_o <= plaintext_i ^ (mode_cbc_i ? chain_eff : 0).
  - chain_eff = iv_i if iv_load_i is high in the same cycle, else chain.
  - Latch the mode. Clear err_o. Go to START.
- START: exactly one cycle with core_start_o=1, then go to WAIT. core_done_i is ignored in START.
- WAIT, core_done_i=1:
  - ciphertext_o <= core_data_i.
  - In CBC mode, chain <= core_data_i.
  - enc_done_o <= 1 for one cycle, go to IDLE.
- Latency: enc_done_o rises one cycle after core_done_i. Minimum enc_cs-to-enc_done is 3 cycles when the core answers in the first WAIT cycle.
- enc_cs_i while busy: ignored and sets overrun_o. overrun_o is cleared only by reset or by iv_load_i in IDLE.
- iv_load_i while busy: ignored. The chain is not corrupted.
- ECB mode never updates the chain.
- core_data_o holds its value until the next accepted start.

Optional Feature:
AES_CBC_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without core_done_i: go to IDLE, pulse enc_done_o, set err_o.
  - ciphertext_o and chain are unchanged on timeout.
  - If core_done_i arrives in the same cycle as expiry, done wins and there is no error.
- Undefined: no counter; WAIT persists until core_done_i, and err_o is constant 0.

Decomposition:
- Package aes_cbc_pkg: state encoding constants (IDLE=2'd0, START=2'd1, WAIT=2'd2) and the BW=128 constant.
- Sub-module aes_cbc_wdog: counter plus expiry compare. Instantiated only under AES_CBC_TIMEOUT_EN.

Test Plan:
- ECB block:
  - Stimulus: mode=0, plaintext 00112233445566778899aabbccddeeff, enc_cs pulse.
  - Required: core_data_o equals the plaintext, and core_start_o is high exactly one cycle, one cycle after enc_cs.
  - Bench model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 10 cycles. Required: ciphertext_o equals that value, enc_done_o pulses once one cycle later, and the chain stays 0.
- CBC two blocks:
  - Stimulus: iv_load with 000102030405060708090a0b0c0d0e0f, P1=all-ones.
  - Required: core_data_o = fffefdfcfbfaf9f8f7f6f5f4f3f2f1f0. Model returns C1=0123456789abcdef0011223344556677.
  - Then P2=0. Required: core_data_o = C1.
- Overrun: enc_cs pulsed again 3 cycles after the first -> exactly one core_start_o, overrun_o=1, result unaffected. A later iv_load in IDLE clears overrun_o.
- Same-cycle IV load: iv_load_i and enc_cs_i together in CBC with iv=ffff...ff, P=0 -> core_data_o = ffff...ff, and chain holds the new IV.
- Reset mid-WAIT: assert wb_rst_i for 1 cycle on WAIT cycle 4, then the model asserts core_done_i -> busy_o=0, enc_done_o never pulses, ciphertext_o=0.
- Timeout (macro defined, TIMEOUT_CYCLES=64): model never answers -> enc_done_o and err_o assert at WAIT cycle 64 and ciphertext_o is unchanged. With the macro undefined, busy_o stays high for 200 cycles.

Source files
------------

// File: rtl/aes_cbc_pkg.sv
// aes_cbc_pkg: shared constants and state encoding for the AES CBC chaining stage.
//   BW      - AES block width (only 128 supported)
//   state_e - sequencing FSM states IDLE / START / WAIT
package aes_cbc_pkg;

    localparam int BW = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/aes_cbc_chain_if.sv
// aes_cbc_chain_if: launch/result handshake between the chaining stage and the
// AES-128 core.
//   core_start_o - one-cycle launch pulse (chain -> core)
//   core_data_o  - block presented to the core (chain -> core)
//   core_done_i  - result valid, one cycle (core -> chain)
//   core_data_i  - ciphertext from the core (core -> chain)
// Modports: master = chaining stage, slave = core.
interface aes_cbc_chain_if #(
    parameter int BW = 128
);
    logic          core_start_o;
    logic [BW-1:0] core_data_o;
    logic          core_done_i;
    logic [BW-1:0] core_data_i;

    modport master (
        output core_start_o,
        output core_data_o,
        input  core_done_i,
        input  core_data_i
    );

    modport slave (
        input  core_start_o,
        input  core_data_o,
        output core_done_i,
        output core_data_i
    );
endinterface

// File: rtl/aes_cbc_wdog.sv
// aes_cbc_wdog: WAIT-state watchdog used when AES_CBC_TIMEOUT_EN is defined.
//   clk, rst - clock, synchronous active-high reset
//   clr      - clear the count (asserted in the cycle before WAIT is entered)
//   en       - count enable (asserted in every WAIT cycle)
//   expired  - high in the WAIT cycle whose count equals TIMEOUT_CYCLES-1
module aes_cbc_wdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The FSM leaves WAIT on expiry, so the count never needs to saturate.
    assign expired = en && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/aes_cbc_chain.sv
// aes_cbc_chain: sequencing stage between the Wishbone AES wrapper and the
// AES-128 core. Optionally XORs the plaintext with the chaining value (CBC),
// launches the core, waits for its result and returns it with a done pulse.
//   wb_clk_i, wb_rst_i         - clock, synchronous active-high reset
//   enc_cs_i, plaintext_i,
//   mode_cbc_i                 - start strobe, block and mode from the wrapper
//   iv_i, iv_load_i            - initialisation vector load (IDLE only)
//   core                       - launch/result handshake to the core
//   ciphertext_o, enc_done_o   - last result and its one-cycle done pulse
//   busy_o, overrun_o, err_o   - status (overrun/err are sticky)
// Optional macro AES_CBC_TIMEOUT_EN adds a WAIT watchdog that ends the block
// with enc_done_o + err_o after TIMEOUT_CYCLES; without it err_o is tied 0.
module aes_cbc_chain
    import aes_cbc_pkg::*;
#(
    parameter int BW             = aes_cbc_pkg::BW,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          enc_cs_i,
    input  logic [BW-1:0] plaintext_i,
    input  logic          mode_cbc_i,
    input  logic [BW-1:0] iv_i,
    input  logic          iv_load_i,
    aes_cbc_chain_if.master core,
    output logic [BW-1:0] ciphertext_o,
    output logic          enc_done_o,
    output logic          busy_o,
    output logic          overrun_o,
    output logic          err_o
);

    state_e        state_q, state_d;
    logic [BW-1:0] core_data_q, core_data_d;
    logic [BW-1:0] ciphertext_q, ciphertext_d;
    logic [BW-1:0] chain_q, chain_d;
    logic [BW-1:0] chain_eff;
    logic          mode_q, mode_d;
    logic          enc_done_q, enc_done_d;
    logic          overrun_q, overrun_d;
    logic          wdog_expired;

`ifdef AES_CBC_TIMEOUT_EN
    logic err_q, err_d;

    aes_cbc_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (state_q == START),
        .en      (state_q == WAIT),
        .expired (wdog_expired)
    );

    assign err_o = err_q;
`else
    wire unused_cfg = (TIMEOUT_CYCLES != 0);
    assign wdog_expired = 1'b0;
    assign err_o        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        core_data_d  = core_data_q;
        ciphertext_d = ciphertext_q;
        chain_d      = chain_q;
        mode_d       = mode_q;
        enc_done_d   = 1'b0;
        overrun_d    = overrun_q;
        // A same-cycle IV load feeds the XOR directly, not via the register.
        chain_eff    = iv_load_i ? iv_i : chain_q;
`ifdef AES_CBC_TIMEOUT_EN
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (iv_load_i) begin
                    chain_d   = iv_i;
                    overrun_d = 1'b0;
                end
                if (enc_cs_i) begin
                    core_data_d = plaintext_i ^ (mode_cbc_i ? chain_eff : '0);
                    mode_d      = mode_cbc_i;
                    state_d     = START;
`ifdef AES_CBC_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            START: begin
                if (enc_cs_i) overrun_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (enc_cs_i) overrun_d = 1'b1;
                // core_done_i has priority over a coincident watchdog expiry.
                if (core.core_done_i) begin
                    ciphertext_d = core.core_data_i;
                    if (mode_q) chain_d = core.core_data_i;
                    enc_done_d   = 1'b1;
                    state_d      = IDLE;
                end else if (wdog_expired) begin
                    enc_done_d = 1'b1;
                    state_d    = IDLE;
`ifdef AES_CBC_TIMEOUT_EN
                    err_d      = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            core_data_q  <= '0;
            ciphertext_q <= '0;
            chain_q      <= '0;
            mode_q       <= 1'b0;
            enc_done_q   <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef AES_CBC_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            core_data_q  <= core_data_d;
            ciphertext_q <= ciphertext_d;
            chain_q      <= chain_d;
            mode_q       <= mode_d;
            enc_done_q   <= enc_done_d;
            overrun_q    <= overrun_d;
`ifdef AES_CBC_TIMEOUT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign core.core_start_o = (state_q == START);
    assign core.core_data_o  = core_data_q;
    assign ciphertext_o      = ciphertext_q;
    assign enc_done_o        = enc_done_q;
    assign busy_o            = (state_q != IDLE);
    assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_aes_cbc_chain.sv
// tb_aes_cbc_chain: directed bench for aes_cbc_chain. The bench plays the
// AES core itself, answering each launch with a fixed ciphertext after a
// chosen number of WAIT cycles. Inputs change and outputs are sampled on the
// falling edge. Covers the AES_CBC_TIMEOUT_EN build when that macro is defined.
module tb_aes_cbc_chain;

    logic         clk = 1'b0;
    logic         rst;
    logic         enc_cs;
    logic [127:0] plaintext;
    logic         mode_cbc;
    logic [127:0] iv;
    logic         iv_load;
    logic [127:0] ciphertext;
    logic         enc_done;
    logic         busy;
    logic         overrun;
    logic         err;

    int nchk = 0;
    int nerr = 0;

    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [127:0] P_ECB = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_ECB = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] IV1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1    = 128'h0123456789abcdef0011223344556677;
    localparam logic [127:0] C2    = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
    localparam logic [127:0] PZ    = 128'ha5a5a5a5_5a5a5a5a_a5a5a5a5_5a5a5a5a;
    localparam logic [127:0] CZ    = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] PX    = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] CY    = 128'h55555555_66666666_77777777_88888888;

    always #5 clk = ~clk;

    aes_cbc_chain_if #(.BW(128)) cif ();

    aes_cbc_chain #(.BW(128), .TIMEOUT_CYCLES(64)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .enc_cs_i     (enc_cs),
        .plaintext_i  (plaintext),
        .mode_cbc_i   (mode_cbc),
        .iv_i         (iv),
        .iv_load_i    (iv_load),
        .core         (cif),
        .ciphertext_o (ciphertext),
        .enc_done_o   (enc_done),
        .busy_o       (busy),
        .overrun_o    (overrun),
        .err_o        (err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start strobe; returns on the falling edge with the DUT in START.
    task automatic start_blk(input logic [127:0] pt, input logic cbc,
                             input logic ld, input logic [127:0] ivv);
        plaintext = pt;
        mode_cbc  = cbc;
        iv_load   = ld;
        iv        = ivv;
        enc_cs    = 1'b1;
        tick();
        enc_cs    = 1'b0;
        iv_load   = 1'b0;
    endtask

    // Core model: after waitc cycles raise core_done_i for one cycle with c.
    task automatic answer(input int waitc, input logic [127:0] c);
        repeat (waitc) tick();
        cif.core_done_i = 1'b1;
        cif.core_data_i = c;
        tick();
        cif.core_done_i = 1'b0;
    endtask

    task automatic load_iv(input logic [127:0] ivv);
        iv      = ivv;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
    endtask

    initial begin
        int bad;
        rst = 1'b1; enc_cs = 1'b0; plaintext = '0; mode_cbc = 1'b0;
        iv = '0; iv_load = 1'b0;
        cif.core_done_i = 1'b0; cif.core_data_i = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", enc_done, 0);
        chk("rst_start", cif.core_start_o, 0);
        chk("rst_ctext", ciphertext, 0);
        chk("rst_cdata", cif.core_data_o, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_err", err, 0);

        // ECB block, core answers after 10 cycles
        start_blk(P_ECB, 1'b0, 1'b0, '0);
        chk("ecb_start_hi", cif.core_start_o, 1);
        chk("ecb_cdata", cif.core_data_o, P_ECB);
        chk("ecb_busy", busy, 1);
        tick();
        chk("ecb_start_lo", cif.core_start_o, 0);
        answer(9, C_ECB);
        chk("ecb_done", enc_done, 1);
        chk("ecb_ctext", ciphertext, C_ECB);
        chk("ecb_idle", busy, 0);
        tick();
        chk("ecb_done_1cyc", enc_done, 0);

        // Chain still 0 after ECB: CBC block without IV sees plaintext only.
        // Core answers in the first WAIT cycle (minimum latency).
        start_blk(PZ, 1'b1, 1'b0, '0);
        chk("chain0_cdata", cif.core_data_o, PZ);
        tick();
        answer(0, CZ);
        chk("minlat_done", enc_done, 1);
        chk("minlat_ctext", ciphertext, CZ);
        tick();

        // CBC two blocks
        load_iv(IV1);
        start_blk(ONES, 1'b1, 1'b0, '0);
        chk("cbc1_cdata", cif.core_data_o, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
        tick();
        answer(4, C1);
        chk("cbc1_ctext", ciphertext, C1);
        tick();
        start_blk('0, 1'b1, 1'b0, '0);
        chk("cbc2_cdata", cif.core_data_o, C1);
        tick();
        answer(2, C2);
        chk("cbc2_ctext", ciphertext, C2);
        tick();

        // Overrun: second strobe (plus an IV load) 3 cycles after the first
        start_blk(PX, 1'b0, 1'b0, '0);
        tick(); tick();
        plaintext = ONES; enc_cs = 1'b1; iv = ONES; iv_load = 1'b1;
        tick();
        enc_cs = 1'b0; iv_load = 1'b0;
        chk("ovr_nostart", cif.core_start_o, 0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_cdata", cif.core_data_o, PX);
        tick();
        chk("ovr_nostart2", cif.core_start_o, 0);
        answer(2, CY);
        chk("ovr_ctext", ciphertext, CY);
        chk("ovr_sticky", overrun, 1);
        tick();

        // Chain is still C2: ECB did not update it, busy IV load was ignored
        start_blk('0, 1'b1, 1'b0, '0);
        chk("chain_kept", cif.core_data_o, C2);
        tick();
        answer(0, CZ);
        tick();

        // IV load in IDLE clears overrun
        load_iv(IV1);
        chk("ovr_clear", overrun, 0);

        // Same-cycle IV load and start
        start_blk('0, 1'b1, 1'b1, ONES);
        chk("samecyc_cdata", cif.core_data_o, ONES);
        chk("samecyc_chain", dut.chain_q, ONES);
        tick();
        answer(1, C1);
        tick();

        // Reset on WAIT cycle 4, then a late core_done_i
        start_blk(P_ECB, 1'b0, 1'b0, '0);
        repeat (4) tick();
        chk("rstw_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_busy", busy, 0);
        chk("rstw_ctext", ciphertext, 0);
        cif.core_done_i = 1'b1;
        cif.core_data_i = C_ECB;
        tick();
        cif.core_done_i = 1'b0;
        chk("rstw_nodone", enc_done, 0);
        chk("rstw_idle", busy, 0);
        tick();
        chk("rstw_nodone2", enc_done, 0);
        chk("rstw_ctext2", ciphertext, 0);

`ifdef AES_CBC_TIMEOUT_EN
        // Watchdog: core never answers; block ends after WAIT cycle 64
        start_blk(PX, 1'b0, 1'b0, '0);
        bad = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (enc_done !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk("to_wait64", bad, 0);
        tick();
        chk("to_done", enc_done, 1);
        chk("to_err", err, 1);
        chk("to_idle", busy, 0);
        chk("to_ctext", ciphertext, 0);
        tick();
        chk("to_done_1cyc", enc_done, 0);
        chk("to_err_sticky", err, 1);
        start_blk(PX, 1'b0, 1'b0, '0);
        chk("to_err_clr", err, 0);
        tick();
        answer(0, CY);
        tick();
`else
        // No watchdog: WAIT persists
        start_blk(PX, 1'b0, 1'b0, '0);
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (busy !== 1'b1 || enc_done !== 1'b0) bad++;
        end
        chk("nowd_busy200", bad, 0);
        chk("nowd_err", err, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
